uart_stream_agent: RTL and testbench

Parametrised, clocked UART transceiver for the Caravel test environment. It replaces the fixed single-byte bench UART with configurable bit timing, data width and stop bits, plus TX and RX FIFOs. It sits on the chip's UART pins: `ser_tx` drives `mprj_io[5]` and `ser_rx` samples `mprj_io[6]`. Workload tasks can then stream multi-byte interrupt payloads and check firmware echoes.

---
 rtl/uart_stream_agent.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_stream_agent.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_agent.sv
// uart_stream_agent: parametrised UART transceiver with TX/RX FIFOs for the Caravel test bench.
// Even parity on both directions is enabled by defining UART_PARITY_EN.
module uart_stream_agent #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_full,
  output logic                 tx_clear_req,
  output logic                 ser_tx,
  input  logic                 ser_rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_parity_err,
  input  logic                 err_clear
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0]  BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]     STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [TXAW:0]  TX_FULL_CNT = (TXAW + 1)'(TX_DEPTH);
  localparam logic [RXAW:0]  RX_FULL_CNT = (RXAW + 1)'(RX_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
`else
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
`endif

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TXAW-1:0]      tx_wr_ptr, tx_rd_ptr;
  logic [TXAW:0]        tx_count;
  logic                 tx_start_q, tx_push, tx_pop, tx_empty;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign tx_push  = tx_start & ~tx_start_q & ~tx_full;

  // NOTE: FIFO storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
  end

  // NOTE: every sequential block uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_start_q <= 1'b0;
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count   <= '0;
    end else begin
      tx_start_q <= tx_start;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count + (TXAW + 1)'(tx_push) - (TXAW + 1)'(tx_pop);
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t            tx_state, tx_state_next;
  logic [CW-1:0]        tx_clk_cnt;
  logic [2:0]           tx_bit_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_bit_done, tx_line, tx_busy_next;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_bit_done  = (tx_clk_cnt == BIT_LAST);
  assign tx_busy_next = ~tx_empty | (tx_state != TX_IDLE);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) tx_state <= TX_IDLE;
    else         tx_state <= tx_state_next;
  end

  // NOTE: each combinational block assigns its defaults first so no path can infer a latch.
  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (!tx_empty) tx_state_next = TX_START;
      TX_START:  if (tx_bit_done) tx_state_next = TX_DATA;
`ifdef UART_PARITY_EN
      TX_DATA:   if (tx_bit_done && tx_bit_idx == DATA_LAST) tx_state_next = TX_PARITY;
      TX_PARITY: if (tx_bit_done) tx_state_next = TX_STOP;
`else
      TX_DATA:   if (tx_bit_done && tx_bit_idx == DATA_LAST) tx_state_next = TX_STOP;
`endif
      // A queued byte starts its START bit right after the last stop bit.
      TX_STOP:   if (tx_bit_done && tx_bit_idx == STOP_LAST)
                   tx_state_next = tx_empty ? TX_IDLE : TX_START;
      default:   tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      TX_IDLE:   tx_pop  = ~tx_empty;
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_line = tx_par;
`endif
      TX_STOP:   tx_pop  = tx_bit_done & (tx_bit_idx == STOP_LAST) & ~tx_empty;
      default:   tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_clk_cnt   <= '0;
      tx_bit_idx   <= '0;
      tx_shift     <= '0;
      ser_tx       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_clear_req <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par       <= 1'b0;
`endif
    end else begin
      ser_tx       <= tx_line;
      tx_busy      <= tx_busy_next;
      tx_clear_req <= tx_busy & ~tx_busy_next;
      if (tx_pop) begin
        tx_shift <= tx_mem[tx_rd_ptr];
`ifdef UART_PARITY_EN
        tx_par   <= ^tx_mem[tx_rd_ptr];
`endif
      end else if (tx_state == TX_DATA && tx_bit_done) begin
        tx_shift <= tx_shift >> 1;
      end
      if (tx_state == TX_IDLE) tx_clk_cnt <= '0;
      else                     tx_clk_cnt <= tx_bit_done ? '0 : tx_clk_cnt + 1'b1;
      if (tx_state_next != tx_state) tx_bit_idx <= '0;
      else if (tx_bit_done)          tx_bit_idx <= tx_bit_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------- RX synchroniser
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------- RX FSM
  rx_state_t            rx_state, rx_state_next;
  logic [CW-1:0]        rx_clk_cnt;
  logic [2:0]           rx_bit_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_bit_done, rx_half_done, rx_par_ok;
  logic                 rx_push, frame_set, parity_set;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad;
  assign rx_par_ok = ~rx_par_bad;
`else
  assign rx_par_ok = 1'b1;
`endif

  assign rx_bit_done  = (rx_clk_cnt == BIT_LAST);
  assign rx_half_done = (rx_clk_cnt == HALF_LAST);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) rx_state <= RX_IDLE;
    else         rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:      if (rx_fall) rx_state_next = RX_START;
      // A line already back high at mid-start was a glitch.
      RX_START:     if (rx_half_done) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
      RX_DATA:      if (rx_bit_done && rx_bit_idx == DATA_LAST) rx_state_next = RX_PARITY;
      RX_PARITY:    if (rx_bit_done) rx_state_next = RX_STOP;
`else
      RX_DATA:      if (rx_bit_done && rx_bit_idx == DATA_LAST) rx_state_next = RX_STOP;
`endif
      RX_STOP:      if (rx_bit_done) rx_state_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_sync) rx_state_next = RX_IDLE;
      default:      rx_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    case (rx_state)
`ifdef UART_PARITY_EN
      RX_PARITY: parity_set = rx_bit_done & (rx_sync != ^rx_shift);
`endif
      RX_STOP: begin
        rx_push   = rx_bit_done & rx_sync & rx_par_ok;
        frame_set = rx_bit_done & ~rx_sync;
      end
      default: rx_push = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_clk_cnt <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      rx_clk_cnt <= (rx_state_next != rx_state || rx_bit_done) ? '0 : rx_clk_cnt + 1'b1;
      if (rx_state_next != rx_state) rx_bit_idx <= '0;
      else if (rx_bit_done)          rx_bit_idx <= rx_bit_idx + 1'b1;
      // LSB arrives first, so shift in from the top.
      if (rx_state == RX_DATA && rx_bit_done)
        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
      if (rx_state == RX_IDLE) rx_par_bad <= 1'b0;
      else if (parity_set)     rx_par_bad <= 1'b1;
`endif
    end
  end

  // ---------------------------------------------------------------- RX FIFO and error flags
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RXAW-1:0]      rx_wr_ptr, rx_rd_ptr;
  logic [RXAW:0]        rx_count;
  logic                 rx_full, rx_pop, rx_accept, overrun_set;

  assign rx_full     = (rx_count == RX_FULL_CNT);
  assign rx_valid    = (rx_count != '0);
  assign rx_pop      = rx_ready & rx_valid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign rx_accept   = rx_push & (~rx_full | rx_pop);
  assign overrun_set = rx_push & rx_full & ~rx_pop;
  assign rx_data     = rx_valid ? rx_mem[rx_rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (rx_accept) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_wr_ptr    <= '0;
      rx_rd_ptr    <= '0;
      rx_count     <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (rx_accept) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count     <= rx_count + (RXAW + 1)'(rx_accept) - (RXAW + 1)'(rx_pop);
      rx_frame_err <= frame_set | (rx_frame_err & ~err_clear);
      rx_overrun   <= overrun_set | (rx_overrun & ~err_clear);
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) rx_parity_err <= 1'b0;
    else         rx_parity_err <= parity_set | (rx_parity_err & ~err_clear);
  end
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_stream_agent.sv
// Directed self-checking bench for uart_stream_agent (CLKS_PER_BIT=8, 8N1, depth 4).
// Parity scenarios run only when UART_PARITY_EN is defined.
module tb_uart_stream_agent;
  localparam int CPB = 8;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clock = 1'b0;
  logic       resetb = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_drive = 1'b1;
  logic       loopback = 1'b0;
  logic       rx_ready = 1'b0;
  logic       err_clear = 1'b0;
  logic       ser_rx;
  logic       tx_busy, tx_full, tx_clear_req, ser_tx;
  logic       rx_valid, rx_frame_err, rx_overrun, rx_parity_err;
  logic [7:0] rx_data;
`ifdef UART_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  assign ser_rx = loopback ? ser_tx : rx_drive;

  uart_stream_agent #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .TX_DEPTH(4), .RX_DEPTH(4)
  ) dut (
    .clock(clock), .resetb(resetb), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_full(tx_full), .tx_clear_req(tx_clear_req), .ser_tx(ser_tx),
    .ser_rx(ser_rx), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err),
    .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Expected wire bits of one frame, index 0 = start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  task automatic send_bit(input logic b);
    rx_drive = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_bit);
    rx_drive = 1'b1;
    tick(CPB);
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
  endtask

  initial begin
    logic [10:0] f1, f2;
    int          bad, lows, busys, pulses, waited;
    logic        par_seen;

    // Reset state
    #1 resetb = 1'b0;
    tick(3);
    check("rst_ser_tx", ser_tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_clear_req", tx_clear_req, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_errs", {rx_frame_err, rx_overrun, rx_parity_err}, 0);
    resetb = 1'b1;
    tick(2);

    // Single frame 0x3D: timing, bit order, tx_clear_req
    push_tx(8'h3D);                         // now just after edge N
    check("tx_n_ser", ser_tx, 1);
    check("tx_n_busy", tx_busy, 0);
    tick(1);
    check("tx_n1_busy", tx_busy, 1);
    check("tx_n1_ser", ser_tx, 1);
    tick(1);
    f1 = frame_of(8'h3D);
    bad = 0; pulses = 0; par_seen = 1'b0;
    for (int c = 0; c < FB * CPB; c++) begin
      if (ser_tx !== f1[c / CPB]) bad++;
      if (tx_clear_req) pulses++;
      if (c == 9 * CPB + 4) par_seen = ser_tx;
      tick(1);
    end
    check("tx_frame_bits", bad, 0);
    check("tx_no_early_clear", pulses, 0);
    check("tx_clear_pulse", tx_clear_req, 1);
    check("tx_busy_fall", tx_busy, 0);
`ifdef UART_PARITY_EN
    check("tx_parity_bit", par_seen, 1);
`endif
    tick(1);
    check("tx_clear_one_cycle", tx_clear_req, 0);

    // TX FIFO fill: one byte in the shifter, four queued, sixth edge dropped
    waited = 0;
    for (int i = 0; i < 6; i++) begin
      tx_data  = 8'hA0 + 8'(i);
      tx_start = 1'b1;
      tick(1);
      if (i == 3) check("tx_not_full_3", tx_full, 0);
      if (i == 4) check("tx_full_4", tx_full, 1);
      tx_start = 1'b0;
      tick(1);
    end
    check("tx_full_after_drop", tx_full, 1);
    waited = 11;
    while (!tx_clear_req && waited < 2000) begin
      tick(1);
      waited++;
    end
    check("tx_drop_total_cycles", waited, 5 * FB * CPB + 2);

    // Reset mid-transmission
    tick(4);
    push_tx(8'h3D);
    tick(20);
    check("mid_ser_low", ser_tx, 0);
    #2 resetb = 1'b0;
    #1;
    check("mid_rst_ser", ser_tx, 1);
    check("mid_rst_flags", {tx_busy, tx_full, tx_clear_req, rx_valid}, 0);
    tick(1);
    resetb = 1'b1;
    lows = 0; busys = 0;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      if (!ser_tx) lows++;
      if (tx_busy) busys++;
    end
    check("post_rst_no_frame", lows, 0);
    check("post_rst_idle", busys, 0);

    // Loopback: two back-to-back frames
    loopback = 1'b1;
    push_tx(8'h0F);                         // after edge N
    tick(2);                                // after N+2
    check("lb_start_low", ser_tx, 0);
    tx_data  = 8'h3D;
    tx_start = 1'b1;
    f1 = frame_of(8'h0F);
    f2 = frame_of(8'h3D);
    bad = 0; pulses = 0;
    for (int c = 0; c < 2 * FB * CPB; c++) begin
      if (c / CPB < FB) begin
        if (ser_tx !== f1[c / CPB]) bad++;
      end else begin
        if (ser_tx !== f2[c / CPB - FB]) bad++;
      end
      if (tx_clear_req) pulses++;
      tick(1);
      if (c == 0) tx_start = 1'b0;
    end
    check("lb_contiguous_bits", bad, 0);
    check("lb_no_mid_clear", pulses, 0);
    check("lb_clear_pulse", tx_clear_req, 1);
    tick(2);
    check("lb_rx_valid", rx_valid, 1);
    check("lb_rx_first", rx_data, 8'h0F);
    pop();
    check("lb_rx_second", rx_data, 8'h3D);
    pop();
    check("lb_rx_empty", rx_valid, 0);
    check("lb_rx_data_zero", rx_data, 0);
    loopback = 1'b0;
    tick(4);

    // Overrun: five frames with no pops
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    check("ovr_not_yet", rx_overrun, 0);
    send_frame(8'h05, 1'b1);
    check("ovr_set", rx_overrun, 1);
    check("ovr_head", rx_data, 8'h01);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("ovr_cleared", rx_overrun, 0);
    bad = 0;
    for (int i = 1; i <= 4; i++) begin
      if (rx_data !== 8'(i) || !rx_valid) bad++;
      pop();
    end
    check("ovr_contents", bad, 0);
    check("ovr_empty", rx_valid, 0);

    // Framing error, long low, glitch
    send_frame(8'h55, 1'b0);
    check("frm_err_set", rx_frame_err, 1);
    check("frm_no_push", rx_valid, 0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("frm_err_cleared", rx_frame_err, 0);
    rx_drive = 1'b0;
    tick(20);
    rx_drive = 1'b1;
    tick(100);
    for (int i = 0; i < 8 && rx_valid; i++) pop();
    check("long_low_drained", rx_valid, 0);
    send_frame(8'hA5, 1'b1);
    check("recov_valid", rx_valid, 1);
    check("recov_data", rx_data, 8'hA5);
    pop();
    rx_drive = 1'b0;
    tick(2);
    rx_drive = 1'b1;
    tick(100);
    check("glitch_no_push", rx_valid, 0);
    check("glitch_no_err", rx_frame_err, 0);

`ifdef UART_PARITY_EN
    // Parity: bad parity is flagged and dropped, good parity still lands
    par_flip = 1'b1;
    send_frame(8'h3D, 1'b1);
    check("par_err_set", rx_parity_err, 1);
    check("par_no_push", rx_valid, 0);
    par_flip = 1'b0;
    send_frame(8'h3D, 1'b1);
    check("par_good_valid", rx_valid, 1);
    check("par_good_data", rx_data, 8'h3D);
    pop();
`else
    check("par_tied_low", rx_parity_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
